// File: rtl/lc3_dbg_pkg.sv
// Shared types and sizing for the LC-3 debug register dump reader.
package lc3_dbg_pkg;

    typedef enum logic [1:0] {IDLE, READ, SEND, FINISH} dump_state_t;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 16;
    localparam int IDX_W    = 3;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks R0..R(NUM_REGS-1) through one register-file read port and streams
// each captured value as an (index, data) beat over a valid/ready handshake.
module regfile_dump_reader #(
    parameter int DATA_W   = lc3_dbg_pkg::DATA_W,
    parameter int NUM_REGS = lc3_dbg_pkg::NUM_REGS,
    parameter int IDX_W    = lc3_dbg_pkg::IDX_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic [IDX_W-1:0]  SR_SEL,
    input  logic [DATA_W-1:0] SR_DATA,
    output logic [DATA_W-1:0] Out_Data,
    output logic [IDX_W-1:0]  Out_Idx,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Busy,
    output logic              Freeze,
    output logic              Done
);

    import lc3_dbg_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    idx_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                out_data_d = SR_DATA;
                out_idx_d  = idx_q;
                state_d    = SEND;
            end
            SEND: begin
                if (Out_Ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = READ;
                    end
                end
            end
            FINISH: begin
                // Park the read select on R0 so IDLE always presents SR_SEL=0.
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy      = (state_q == READ) || (state_q == SEND);
        Freeze    = Busy;
        Out_Valid = (state_q == SEND);
        Done      = (state_q == FINISH);
    end

    assign SR_SEL   = idx_q;
    assign Out_Data = out_data_q;
    assign Out_Idx  = out_idx_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural LC-3 register file.
module tb_regfile_dump_reader;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  SR_SEL;
    logic [15:0] SR_DATA;
    logic [15:0] Out_Data;
    logic [2:0]  Out_Idx;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Busy;
    logic        Freeze;
    logic        Done;

    logic        ld_reg;
    logic [2:0]  dr;
    logic [15:0] bus;
    logic [15:0] rf [8];

    int compared   = 0;
    int mismatched = 0;

    always #5 Clk = ~Clk;

    // Register file: write port gated by the freeze request, combinational SR1 read.
    always @(posedge Clk) begin
        if (ld_reg && !Freeze) rf[dr] <= bus;
    end
    assign SR_DATA = rf[SR_SEL];

    regfile_dump_reader dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .SR_SEL    (SR_SEL),
        .SR_DATA   (SR_DATA),
        .Out_Data  (Out_Data),
        .Out_Idx   (Out_Idx),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Busy      (Busy),
        .Freeze    (Freeze),
        .Done      (Done)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sr_sel"}, 32'(SR_SEL), 32'h0);
        check({tag, "_out_data"}, 32'(Out_Data), 32'h0);
        check({tag, "_out_idx"}, 32'(Out_Idx), 32'h0);
        check({tag, "_out_valid"}, 32'(Out_Valid), 32'h0);
        check({tag, "_busy"}, 32'(Busy), 32'h0);
        check({tag, "_freeze"}, 32'(Freeze), 32'h0);
        check({tag, "_done"}, 32'(Done), 32'h0);
    endtask

    // Called just after the edge that sampled Start. Consumes one dump, checking
    // every beat, hold stability during stalls, and the cycle Done appears in
    // (cycle 1 is the one right after the Start edge).
    task automatic collect(input int stall_beat, input int stall_len,
                           input bit try_load, input int exp_done_cycle);
        int          beat;
        int          stall_cnt;
        int          done_cyc;
        int          first_v;
        bit          seen;
        logic [15:0] hold_d;
        logic [2:0]  hold_i;
        beat      = 0;
        stall_cnt = 0;
        done_cyc  = -1;
        first_v   = -1;
        seen      = 1'b0;
        hold_d    = '0;
        hold_i    = '0;
        Out_Ready = 1'b1;
        if (try_load) begin
            ld_reg = 1'b1;
            dr     = 3'd2;
            bus    = 16'hBEEF;
        end
        for (int cyc = 1; cyc <= 100 && done_cyc < 0; cyc++) begin
            tick();
            if (cyc == 14) ld_reg = 1'b0;
            if (Out_Valid) begin
                if (first_v < 0) first_v = cyc;
                if (!seen) begin
                    check("beat_idx", 32'(Out_Idx), 32'(beat));
                    check("beat_data", 32'(Out_Data), 32'h1000 + 32'(beat));
                    hold_d = Out_Data;
                    hold_i = Out_Idx;
                    seen   = 1'b1;
                end else begin
                    check("hold_idx", 32'(Out_Idx), 32'(hold_i));
                    check("hold_data", 32'(Out_Data), 32'(hold_d));
                end
                if (beat == stall_beat && stall_cnt < stall_len) begin
                    Out_Ready = 1'b0;
                    stall_cnt++;
                end else begin
                    Out_Ready = 1'b1;
                    beat++;
                    seen = 1'b0;
                end
            end
            if (Done) done_cyc = cyc + 1;
        end
        ld_reg = 1'b0;
        check("beat_count", 32'(beat), 32'd8);
        check("first_valid_edge", 32'(first_v), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'(exp_done_cycle));
        check("busy_in_finish", 32'(Busy), 32'h0);
        check("stall_cycles", 32'(stall_cnt), 32'(stall_len));
    endtask

    initial begin
        int done_seen;
        Reset     = 1'b1;
        Start     = 1'b0;
        Out_Ready = 1'b0;
        ld_reg    = 1'b0;
        dr        = '0;
        bus       = '0;

        tick();
        tick();
        check_reset_outputs("reset");
        Reset = 1'b0;
        tick();
        check_reset_outputs("idle");

        // Preload R0..R7 = 16'h1000+i through the normal load path.
        for (int i = 0; i < 8; i++) begin
            ld_reg = 1'b1;
            dr     = 3'(i);
            bus    = 16'h1000 + 16'(i);
            tick();
        end
        ld_reg = 1'b0;
        check("preload_r7", 32'(rf[7]), 32'h1007);

        // Full dump with Out_Ready tied high.
        Out_Ready = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("read_busy", 32'(Busy), 32'h1);
        check("read_freeze", 32'(Freeze), 32'h1);
        check("read_valid", 32'(Out_Valid), 32'h0);
        check("read_sr_sel", 32'(SR_SEL), 32'h0);
        collect(-1, 0, 1'b0, 17);
        tick();
        check("done_one_cycle", 32'(Done), 32'h0);
        check("idle_busy", 32'(Busy), 32'h0);
        check("idle_sr_sel", 32'(SR_SEL), 32'h0);

        // Consumer stalls beat 3 for five cycles.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        collect(3, 5, 1'b0, 22);
        tick();

        // Start held high: no restart mid-dump, back-to-back dump after IDLE.
        Start = 1'b1;
        tick();
        collect(-1, 0, 1'b0, 17);
        tick();
        check("b2b_idle_busy", 32'(Busy), 32'h0);
        check("b2b_idle_done", 32'(Done), 32'h0);
        tick();
        check("b2b_restart_busy", 32'(Busy), 32'h1);
        Start = 1'b0;
        collect(-1, 0, 1'b0, 17);
        tick();

        // Load of R2 attempted while the dump is frozen.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        collect(-1, 0, 1'b1, 17);
        tick();
        check("frozen_r2", 32'(rf[2]), 32'h1002);

        // Reset during the SEND of beat 5.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Out_Ready = 1'b1;
        repeat (11) tick();
        check("pre_reset_valid", 32'(Out_Valid), 32'h1);
        check("pre_reset_idx", 32'(Out_Idx), 32'h5);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_reset_outputs("mid_reset");
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Done || Busy) done_seen++;
        end
        check("no_done_after_reset", 32'(done_seen), 32'h0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        collect(-1, 0, 1'b0, 17);
        tick();

        // Start and Reset together: Reset wins.
        Start = 1'b1;
        Reset = 1'b1;
        tick();
        Start = 1'b0;
        Reset = 1'b0;
        check("start_reset_busy", 32'(Busy), 32'h0);
        tick();
        check("start_reset_stay_idle", 32'(Busy), 32'h0);
        check("start_reset_valid", 32'(Out_Valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
